// File: rtl/hps_system_keys_poller.sv
// Avalon-MM master that periodically reads the keys PIO data register, debounces the
// sampled vector and produces stable levels, press/release pulses and a sticky irq.
module hps_system_keys_poller #(
    parameter int WIDTH            = 4,
    parameter int POLL_PERIOD      = 50000,
    parameter int DEBOUNCE_SAMPLES = 10,
    parameter int KEY_ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    output logic [WIDTH-1:0] keys_stable,
    output logic [WIDTH-1:0] key_pressed,
    output logic [WIDTH-1:0] key_released,
    output logic             irq,
    input  logic             irq_clear
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int MW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;

    localparam logic [PW-1:0]    PERIOD_INIT   = PW'(POLL_PERIOD - 1);
    localparam logic [PW-1:0]    PERIOD_RELOAD = PW'(POLL_PERIOD - 3);
    localparam logic [MW-1:0]    MATCH_MAX     = MW'(DEBOUNCE_SAMPLES - 1);
    localparam logic [MW-1:0]    MATCH_PRE     = MW'(DEBOUNCE_SAMPLES - 2);
    localparam logic [WIDTH-1:0] REL_LEVEL     = {WIDTH{KEY_ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        S_WAIT,
        S_READ,
        S_CAPTURE
    } state_t;

    state_t           state;
    logic [PW-1:0]    period_cnt;
    logic [MW-1:0]    match_cnt;
    logic [WIDTH-1:0] prev_sample;

    logic [WIDTH-1:0] sample;
    logic             same;
    logic             accept;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] press_vec;
    logic [WIDTH-1:0] rel_vec;

    assign avm_address = 2'b00;

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_upper;
            assign unused_upper = ^avm_readdata[31:WIDTH];
        end
    endgenerate

    // Accepting on the step that brings the count to its ceiling makes the vector
    // take effect on the DEBOUNCE_SAMPLES-th identical sample, counting the first one.
    always_comb begin
        sample    = avm_readdata[WIDTH-1:0];
        same      = (sample == prev_sample);
        accept    = same && (match_cnt >= MATCH_PRE) && (sample != keys_stable);
        delta     = sample ^ keys_stable;
        press_vec = delta & (sample ^ REL_LEVEL);
        rel_vec   = delta & ~(sample ^ REL_LEVEL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_WAIT;
            period_cnt   <= PERIOD_INIT;
            match_cnt    <= '0;
            prev_sample  <= REL_LEVEL;
            keys_stable  <= REL_LEVEL;
            key_pressed  <= '0;
            key_released <= '0;
            avm_read     <= 1'b0;
            irq          <= 1'b0;
        end else begin
            avm_read     <= 1'b0;
            key_pressed  <= '0;
            key_released <= '0;
            if (irq_clear) begin
                irq <= 1'b0;
            end
            case (state)
                S_WAIT: begin
                    if (period_cnt == '0) begin
                        state    <= S_READ;
                        avm_read <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt - 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state      <= S_WAIT;
                    period_cnt <= PERIOD_RELOAD;
                    if (!same) begin
                        prev_sample <= sample;
                        match_cnt   <= '0;
                    end else if (match_cnt < MATCH_MAX) begin
                        match_cnt <= match_cnt + 1'b1;
                    end
                    if (accept) begin
                        keys_stable  <= sample;
                        key_pressed  <= press_vec;
                        key_released <= rel_vec;
                        // A press in the same cycle as irq_clear keeps irq set.
                        if (|press_vec) begin
                            irq <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hps_system_keys_poller.sv
// Bench for hps_system_keys_poller: table-driven poll sequences, randomized polls
// against a run-length debounce model, and an asynchronous reset during a capture.
module tb_hps_system_keys_poller;

    localparam int W = 4;
    localparam int P = 4;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic [W-1:0] keys_stable;
    logic [W-1:0] key_pressed;
    logic [W-1:0] key_released;
    logic         irq;
    logic         irq_clear;
    logic [W-1:0] in_port;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_read_cyc;

    // Reference model state: stable vector, last sample and its run length.
    logic [W-1:0] m_ks, m_prev, m_pr, m_rl;
    logic         m_irq;
    int           m_run;

    typedef struct {
        logic [W-1:0] in;
        logic         clr;
        logic [W-1:0] ks;
        logic [W-1:0] pr;
        logic [W-1:0] rl;
        logic         irq;
    } vec_t;

    vec_t tbl[23];

    hps_system_keys_poller #(
        .WIDTH(W), .POLL_PERIOD(P), .DEBOUNCE_SAMPLES(D), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .keys_stable(keys_stable),
        .key_pressed(key_pressed),
        .key_released(key_released),
        .irq(irq),
        .irq_clear(irq_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: registered readdata, latency 1, upper bits are noise.
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= {28'($urandom), in_port};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ks = '1; m_prev = '1; m_run = 1; m_irq = 1'b0; m_pr = '0; m_rl = '0;
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] ks,
                                 input logic [W-1:0] pr, input logic [W-1:0] rl,
                                 input logic iq);
        chk({tag, " keys_stable"}, 32'(keys_stable), 32'(ks));
        chk({tag, " key_pressed"}, 32'(key_pressed), 32'(pr));
        chk({tag, " key_released"}, 32'(key_released), 32'(rl));
        chk({tag, " irq"}, 32'(irq), 32'(iq));
        chk({tag, " avm_address"}, 32'(avm_address), 32'd0);
        $display("poll %s in=%h clr=%0d ks=%h pr=%h rl=%h irq=%0d",
                 tag, in_port, irq_clear, keys_stable, key_pressed, key_released, irq);
    endtask

    // One full poll: wait for the read, hold irq_clear through the capture edge,
    // stop #1 after the edge that updates keys_stable.
    task automatic poll(input logic [W-1:0] v, input logic clr, input string tag);
        bit seen = 0;
        in_port   = v;
        irq_clear = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (avm_read) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s read_timeout actual=no_read required=read_within_20", tag);
        end else begin
            chk({tag, " read_period"}, 32'(cyc - last_read_cyc), 32'(P));
            last_read_cyc = cyc;
        end
        @(posedge clk); #1;
        chk({tag, " read_one_cycle"}, 32'(avm_read), 32'd0);
        irq_clear = clr;
        @(posedge clk); #1;
        if (v != m_prev) begin
            m_prev = v;
            m_run  = 1;
        end else if (m_run < D) begin
            m_run++;
        end
        m_pr = '0;
        m_rl = '0;
        if (m_run >= D && v != m_ks) begin
            m_pr = (m_ks ^ v) & ~v;
            m_rl = (m_ks ^ v) & v;
            m_ks = v;
        end
        if (m_pr != '0) m_irq = 1'b1;
        else if (clr)   m_irq = 1'b0;
    endtask

    task automatic quiet_check(input string tag);
        irq_clear = 1'b0;
        @(posedge clk); #1;
        chk({tag, " pulse_pr_gone"}, 32'(key_pressed), 32'd0);
        chk({tag, " pulse_rl_gone"}, 32'(key_released), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rv;
        // in, clr -> expected keys_stable, key_pressed, key_released, irq
        tbl[0]  = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{4'hE, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{4'hE, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{4'hE, 1'b0, 4'hE, 4'h1, 4'h0, 1'b1};
        tbl[5]  = '{4'hE, 1'b1, 4'hE, 4'h0, 4'h0, 1'b0};
        tbl[6]  = '{4'hF, 1'b0, 4'hE, 4'h0, 4'h0, 1'b0};
        tbl[7]  = '{4'hF, 1'b0, 4'hE, 4'h0, 4'h0, 1'b0};
        tbl[8]  = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h1, 1'b0};
        tbl[9]  = '{4'hE, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[10] = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{4'hE, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[12] = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[13] = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[14] = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[15] = '{4'hE, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[16] = '{4'hE, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[17] = '{4'hE, 1'b0, 4'hE, 4'h1, 4'h0, 1'b1};
        tbl[18] = '{4'hE, 1'b1, 4'hE, 4'h0, 4'h0, 1'b0};
        tbl[19] = '{4'hB, 1'b0, 4'hE, 4'h0, 4'h0, 1'b0};
        tbl[20] = '{4'hB, 1'b0, 4'hE, 4'h0, 4'h0, 1'b0};
        tbl[21] = '{4'hB, 1'b1, 4'hB, 4'h4, 4'h1, 1'b1};
        tbl[22] = '{4'hB, 1'b0, 4'hB, 4'h0, 4'h0, 1'b1};

        reset_n   = 1'b0;
        irq_clear = 1'b0;
        in_port   = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset avm_read", 32'(avm_read), 32'd0);
        check_outputs("reset", 4'hF, 4'h0, 4'h0, 1'b0);
        #1;
        reset_n = 1'b1;
        last_read_cyc = cyc;

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            poll(tbl[i].in, tbl[i].clr, tag);
            check_outputs(tag, tbl[i].ks, tbl[i].pr, tbl[i].rl, tbl[i].irq);
            quiet_check(tag);
        end

        rv = 4'hB;
        for (int i = 0; i < 60; i++) begin
            string tag;
            logic  clr;
            tag = $sformatf("rnd%0d", i);
            if ($urandom_range(3) == 0) rv = W'($urandom_range(15));
            clr = ($urandom_range(3) == 0);
            poll(rv, clr, tag);
            check_outputs(tag, m_ks, m_pr, m_rl, m_irq);
            quiet_check(tag);
        end

        // Settle on F, then start a change to 0 and reset during its third capture.
        for (int i = 0; i < 3; i++) begin
            poll(4'hF, 1'b0, "pre_f");
            check_outputs("pre_f", m_ks, m_pr, m_rl, m_irq);
            quiet_check("pre_f");
        end
        for (int i = 0; i < 2; i++) begin
            poll(4'h0, 1'b0, "pend");
            check_outputs("pend", m_ks, m_pr, m_rl, m_irq);
            quiet_check("pend");
        end
        in_port = 4'h0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (avm_read) break;
        end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst avm_read", 32'(avm_read), 32'd0);
        check_outputs("midrst", 4'hF, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        check_outputs("midrst_hold", 4'hF, 4'h0, 4'h0, 1'b0);
        #1;
        reset_n = 1'b1;
        last_read_cyc = cyc;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            string tag;
            tag = $sformatf("post%0d", i);
            poll(4'h0, 1'b0, tag);
            check_outputs(tag, m_ks, m_pr, m_rl, m_irq);
            quiet_check(tag);
        end
        chk("post keys_stable", 32'(keys_stable), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
